// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the CPU and an external requester
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/addr/read_op/write_op/wdata  CPU access request and fields
//   ext_req/addr/read_op/write_op/wdata  external (debug/DMA) access request and fields
//   cpu_gnt, ext_gnt                access issued this cycle (combinational)
//   cpu_rvalid, ext_rvalid          read data valid, cycle after a granted read
//   rdata                           mem_rdata pass-through, qualified by *_rvalid
//   mem_addr/read_op/write_op/wdata memory port request fields
//   mem_rdata                       memory read data
//   owner                           1 when ext is granted this cycle, else 0
// Op encodings: LNONE = 3'd0, SNONE = 2'd0 (any other value is a real access).
// Config: MEM_ARB_RR_EN selects round-robin arbitration on contention; otherwise
//   fixed CPU priority with an ext starvation override after MAX_WAIT stall cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_read_op,
    input  logic [1:0]        cpu_write_op,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [2:0]        ext_read_op,
    input  logic [1:0]        ext_write_op,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_read_op,
    output logic [1:0]        mem_write_op,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);
    localparam logic [2:0] LNONE = 3'd0;
    localparam logic [1:0] SNONE = 2'd0;

    logic rd_pend, rd_owner, ext_win;

`ifdef MEM_ARB_RR_EN
    logic last_winner;
    always_ff @(posedge clk) begin
        if (reset)
            last_winner <= 1'b0;
        else if (cpu_gnt || ext_gnt)
            last_winner <= ext_gnt;
    end
    assign ext_win = !last_winner;
`else
    localparam logic [7:0] MW = 8'(MAX_WAIT);
    logic [7:0] wait_cnt;
    always_ff @(posedge clk) begin
        if (reset || !ext_req || ext_gnt)
            wait_cnt <= 8'd0;
        else if (wait_cnt != MW)
            wait_cnt <= wait_cnt + 8'd1;
    end
    assign ext_win = wait_cnt == MW;
`endif

    always_comb begin
        cpu_gnt      = !reset && cpu_req && (!ext_req || !ext_win);
        ext_gnt      = !reset && ext_req && (!cpu_req || ext_win);
        owner        = ext_gnt;
        mem_addr     = cpu_gnt ? cpu_addr     : ext_gnt ? ext_addr     : '0;
        mem_read_op  = cpu_gnt ? cpu_read_op  : ext_gnt ? ext_read_op  : LNONE;
        mem_write_op = cpu_gnt ? cpu_write_op : ext_gnt ? ext_write_op : SNONE;
        mem_wdata    = cpu_gnt ? cpu_wdata    : ext_gnt ? ext_wdata    : '0;
        // reset in the data-return cycle suppresses the pending rvalid
        cpu_rvalid   = !reset && rd_pend && !rd_owner;
        ext_rvalid   = !reset && rd_pend && rd_owner;
        rdata        = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (cpu_gnt && cpu_read_op != LNONE) || (ext_gnt && ext_read_op != LNONE);
            rd_owner <= ext_gnt;
        end
    end
endmodule
